// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer on a valid/ready interface.
// Define IMMGEN_ZICSR_EN to decode the SYSTEM opcode as a zero-extended CSR uimm (type 6).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [31:0]       ir_i,
  input  logic              ir_valid_i,
  output logic              ir_ready_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [2:0]        imm_type_o,
  output logic              imm_illegal_o,
  output logic              imm_valid_o,
  input  logic              imm_ready_i,
  output logic [CNT_W-1:0]  beat_cnt_o
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
`ifdef IMMGEN_ZICSR_EN
  localparam logic [2:0] T_Z    = 3'd6;
`endif

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e            state_q, state_d;
  beat_t             out_q, out_d, skid_q, skid_d, in_beat;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, consume;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic beat_t decode(input logic [31:0] ir);
    beat_t b;
    b     = '0;
    b.ill = (ir[1:0] != 2'b11);
    case (ir[6:0])
      7'b0110111, 7'b0010111: begin
        b.typ = T_U;
        b.imm = sext32({ir[31:12], 12'b0});
      end
      7'b1101111: begin
        b.typ = T_J;
        b.imm = sext32({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        b.typ = T_I;
        b.imm = sext32({{20{ir[31]}}, ir[31:20]});
      end
      // OP-IMM-32 only exists on RV64
      7'b0011011: begin
        if (XLEN == 64) begin
          b.typ = T_I;
          b.imm = sext32({{20{ir[31]}}, ir[31:20]});
        end
      end
      7'b0100011: begin
        b.typ = T_S;
        b.imm = sext32({{20{ir[31]}}, ir[31:25], ir[11:7]});
      end
      7'b1100011: begin
        b.typ = T_B;
        b.imm = sext32({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      end
`ifdef IMMGEN_ZICSR_EN
      7'b1110011: begin
        b.typ = T_Z;
        b.imm = XLEN'(ir[19:15]);
      end
`endif
      default: b = b;
    endcase
    return b;
  endfunction

  assign ir_ready_o    = (state_q != TWO);
  assign imm_valid_o   = (state_q != EMPTY);
  assign imm_o         = out_q.imm;
  assign imm_type_o    = out_q.typ;
  assign imm_illegal_o = out_q.ill;
  assign beat_cnt_o    = cnt_q;
  assign accept        = ir_valid_i & ir_ready_o;
  assign consume       = imm_valid_o & imm_ready_i;

  always_comb begin
    in_beat = decode(ir_i);
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = consume ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          out_d = in_beat;
        end else if (accept) begin
          skid_d  = in_beat;
          state_d = TWO;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only kills validity; the consume counter above still advances
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 instance plus an XLEN=64 instance with a 3-bit counter.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, ir_valid, imm_ready;
  logic [31:0] ir;

  logic        ir_ready32, illegal32, valid32;
  logic [31:0] imm32;
  logic [2:0]  type32;
  logic [15:0] cnt32;

  logic        ir_ready64, illegal64, valid64;
  logic [63:0] imm64;
  logic [2:0]  type64;
  logic [2:0]  cnt64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ir_i(ir), .ir_valid_i(ir_valid),
    .ir_ready_o(ir_ready32), .imm_o(imm32), .imm_type_o(type32), .imm_illegal_o(illegal32),
    .imm_valid_o(valid32), .imm_ready_i(imm_ready), .beat_cnt_o(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(3)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ir_i(ir), .ir_valid_i(ir_valid),
    .ir_ready_o(ir_ready64), .imm_o(imm64), .imm_type_o(type64), .imm_illegal_o(illegal64),
    .imm_valid_o(valid64), .imm_ready_i(imm_ready), .beat_cnt_o(cnt64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] e_imm, input logic [2:0] e_typ,
                       input logic e_ill);
    chk({tag, "_imm"}, {32'b0, imm32}, {32'b0, e_imm});
    chk({tag, "_type"}, {61'b0, type32}, {61'b0, e_typ});
    chk({tag, "_ill"}, {63'b0, illegal32}, {63'b0, e_ill});
    chk({tag, "_vld"}, {63'b0, valid32}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ir_valid = 1'b0; imm_ready = 1'b0; ir = 32'h0;
    tick(); tick();
    chk("rst_imm", {32'b0, imm32}, 64'd0);
    chk("rst_type", {61'b0, type32}, 64'd0);
    chk("rst_ill", {63'b0, illegal32}, 64'd0);
    chk("rst_vld", {63'b0, valid32}, 64'd0);
    chk("rst_rdy", {63'b0, ir_ready32}, 64'd1);
    chk("rst_cnt", {48'b0, cnt32}, 64'd0);
    rst_n = 1'b1;

    // single addi, one-cycle latency, counted on consume
    ir = 32'hFFF00093; ir_valid = 1'b1; imm_ready = 1'b1;
    tick();
    chk32("addi", 32'hFFFFFFFF, 3'd1, 1'b0);
    chk("addi_cnt0", {48'b0, cnt32}, 64'd0);
    chk("addi64", imm64, 64'hFFFFFFFFFFFFFFFF);
    ir_valid = 1'b0;
    tick();
    chk("addi_cnt1", {48'b0, cnt32}, 64'd1);
    chk("addi_vld0", {63'b0, valid32}, 64'd0);

    // back-to-back stream, one beat per cycle
    ir_valid = 1'b1;
    ir = 32'hFE000EE3; tick();
    chk32("beq", 32'hFFFFFFFC, 3'd3, 1'b0);
    chk("beq64", imm64, 64'hFFFFFFFFFFFFFFFC);
    ir = 32'h800000EF; tick();
    chk32("jal", 32'hFFF00000, 3'd5, 1'b0);
    chk("jal_cnt", {48'b0, cnt32}, 64'd2);
    ir = 32'hFE112E23; tick();
    chk32("sw", 32'hFFFFFFFC, 3'd2, 1'b0);
    ir = 32'h800000B7; tick();
    chk32("lui32", 32'h80000000, 3'd4, 1'b0);
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    chk("lui64_type", {61'b0, type64}, 64'd4);
    ir = 32'h34029073; tick();
    chk32("csrrw", 32'h0, 3'd0, 1'b0);
    ir = 32'hFFF00091; tick();
    chk32("illegal", 32'h0, 3'd0, 1'b1);
    chk("illegal64", {63'b0, illegal64}, 64'd1);
    ir = 32'hFFF0009B; tick();
    chk32("addiw32", 32'h0, 3'd0, 1'b0);
    chk("addiw64_type", {61'b0, type64}, 64'd1);
    chk("addiw64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    ir_valid = 1'b0; tick();
    chk("stream_vld0", {63'b0, valid32}, 64'd0);
    chk("stream_cnt", {48'b0, cnt32}, 64'd8);

    // back-pressure: only two beats fit
    imm_ready = 1'b0; ir_valid = 1'b1;
    ir = 32'h00100093; tick();
    chk32("bp_a", 32'd1, 3'd1, 1'b0);
    chk("bp_rdy1", {63'b0, ir_ready32}, 64'd1);
    ir = 32'h00200093; tick();
    chk("bp_rdy2", {63'b0, ir_ready32}, 64'd0);
    chk("bp_hold2", {32'b0, imm32}, 64'd1);
    ir = 32'h00300093; tick();
    chk("bp_rdy3", {63'b0, ir_ready32}, 64'd0);
    chk("bp_hold3", {32'b0, imm32}, 64'd1);
    ir = 32'h00400093; tick();
    chk("bp_hold4", {32'b0, imm32}, 64'd1);
    ir_valid = 1'b0; imm_ready = 1'b1; tick();
    chk32("bp_b", 32'd2, 3'd1, 1'b0);
    chk("bp_rdy_rel", {63'b0, ir_ready32}, 64'd1);
    tick();
    chk("bp_empty", {63'b0, valid32}, 64'd0);
    chk("bp_cnt", {48'b0, cnt32}, 64'd10);

    // flush from TWO, then flush racing an accept from EMPTY
    imm_ready = 1'b0; ir_valid = 1'b1;
    ir = 32'h00100093; tick();
    ir = 32'h00200093; tick();
    chk("fl_two_rdy", {63'b0, ir_ready32}, 64'd0);
    flush = 1'b1; ir = 32'h00300093; tick();
    chk("fl_vld", {63'b0, valid32}, 64'd0);
    chk("fl_rdy", {63'b0, ir_ready32}, 64'd1);
    ir = 32'h00400093; tick();
    chk("fl_acc_vld", {63'b0, valid32}, 64'd0);
    flush = 1'b0; ir_valid = 1'b0; imm_ready = 1'b1; tick(); tick();
    chk("fl_later_vld", {63'b0, valid32}, 64'd0);
    chk("fl_cnt", {48'b0, cnt32}, 64'd10);
    chk("cnt64_wrap", {61'b0, cnt64}, 64'd2);

    // asynchronous reset drops a buffered beat without a clock edge
    imm_ready = 1'b0; ir_valid = 1'b1; ir = 32'h00500093; tick();
    chk("ar_pre_vld", {63'b0, valid32}, 64'd1);
    ir_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", {63'b0, valid32}, 64'd0);
    chk("ar_imm", {32'b0, imm32}, 64'd0);
    chk("ar_cnt", {48'b0, cnt32}, 64'd0);
    chk("ar_rdy", {63'b0, ir_ready32}, 64'd1);
    tick();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
